// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared state type, mask types and radius-3 circle geometry for FAST corner detection
package fast_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DONE     = 2'd2
    } fast_state_t;

    typedef logic [15:0] circle_mask_t;
    typedef logic [4:0]  arc_len_t;

    localparam int CIRCLE_N = 16;

    // Circle runs clockwise from straight up; negative dy points at older lines.
    function automatic int circle_dx(input logic [3:0] k);
        case (k)
            4'd1, 4'd7:          return 1;
            4'd2, 4'd6:          return 2;
            4'd3, 4'd4, 4'd5:    return 3;
            4'd9, 4'd15:         return -1;
            4'd10, 4'd14:        return -2;
            4'd11, 4'd12, 4'd13: return -3;
            default:             return 0;
        endcase
    endfunction

    function automatic int circle_dy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd15:   return -3;
            4'd2, 4'd14:         return -2;
            4'd3, 4'd13:         return -1;
            4'd5, 4'd11:         return 1;
            4'd6, 4'd10:         return 2;
            4'd7, 4'd8, 4'd9:    return 3;
            default:             return 0;
        endcase
    endfunction

endpackage

// File: rtl/fast_arc_detect.sv
// rtl/fast_arc_detect.sv - flags a circular run of at least arc_len set bits in a 16-bit circle mask
module fast_arc_detect
    import fast_pkg::*;
(
    input  logic [15:0] mask,
    input  logic [4:0]  arc_len,
    output logic        hit
);

    always_comb begin
        logic run_ok;
        hit    = 1'b0;
        run_ok = 1'b0;
        for (int s = 0; s < CIRCLE_N; s++) begin
            run_ok = 1'b1;
            for (int j = 0; j < CIRCLE_N; j++) begin
                if ((5'(j) < arc_len) && !mask[4'(s + j)]) begin
                    run_ok = 1'b0;
                end
            end
            hit = hit | run_ok;
        end
    end

endmodule

// File: rtl/fast_corner_detect.sv
// rtl/fast_corner_detect.sv - three-stage FAST corner test on the centre of a streamed 7x7 window
module fast_corner_detect
    import fast_pkg::*;
#(
    parameter int PIXEL_DEPTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int ARC_LEN     = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_sof,
    input  logic [6:0][6:0][PIXEL_DEPTH-1:0] win,
    input  logic [PIXEL_DEPTH-1:0]           threshold,
    output logic                             out_valid,
    output logic                             out_corner,
    output logic [PIXEL_DEPTH+3:0]           out_score,
    output logic [$clog2(IMG_WIDTH)-1:0]     out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]    out_y,
    output logic                             out_eof
);

    localparam int PD = PIXEL_DEPTH;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int SW = PD + 4;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(6);
    localparam logic [YW-1:0] Y_MIN  = YW'(6);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_HALF = XW'(3);
    localparam logic [YW-1:0] Y_HALF = YW'(3);
    localparam logic [4:0]    ARC    = 5'(ARC_LEN);

    fast_state_t      state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [PD-1:0]    thr_q, thr_d;

    logic             start, accept, last_px;
    logic [XW-1:0]    px;
    logic [YW-1:0]    py;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_eof_q, s1_eof_d;
    logic [XW-1:0]    s1_x_q, s1_x_d;
    logic [YW-1:0]    s1_y_q, s1_y_d;
    logic [15:0]      bright_q, bright_d;
    logic [15:0]      dark_q, dark_d;
    logic [15:0][PD-1:0] bdiff_q, bdiff_d;
    logic [15:0][PD-1:0] ddiff_q, ddiff_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_eof_q, s2_eof_d;
    logic [XW-1:0]    s2_x_q, s2_x_d;
    logic [YW-1:0]    s2_y_q, s2_y_d;
    logic             bhit_q, bhit_d;
    logic             dhit_q, dhit_d;
    logic [SW-1:0]    bsum_q, bsum_d;
    logic [SW-1:0]    dsum_q, dsum_d;

    logic             out_valid_q, out_valid_d;
    logic             out_corner_q, out_corner_d;
    logic [SW-1:0]    out_score_q, out_score_d;
    logic [XW-1:0]    out_x_q, out_x_d;
    logic [YW-1:0]    out_y_q, out_y_d;
    logic             out_eof_q, out_eof_d;

    logic             bright_hit, dark_hit;

    // A sof pixel is always taken at (0,0), whatever the current state.
    always_comb begin
        start   = in_valid && in_sof;
        accept  = start || (in_valid && (state_q == ACTIVE));
        px      = start ? '0 : x_q;
        py      = start ? '0 : y_q;
        last_px = (px == X_LAST) && (py == Y_LAST);
        thr_d   = start ? threshold : thr_q;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (accept) begin
            state_d = last_px ? DONE : ACTIVE;
            if (px == X_LAST) begin
                x_d = '0;
                y_d = py + Y_ONE;
            end else begin
                x_d = px + X_ONE;
                y_d = py;
            end
        end
    end

    always_comb begin
        logic [PD-1:0]        c;
        logic [PD-1:0]        p;
        logic [PD:0]          c_plus_t;
        logic signed [PD+1:0] c_minus_t;
        logic [2:0]           r;
        logic [2:0]           col;
        c          = win[3][3];
        p          = '0;
        r          = '0;
        col        = '0;
        c_plus_t   = {1'b0, c} + {1'b0, thr_d};
        c_minus_t  = $signed({2'b00, c}) - $signed({2'b00, thr_d});
        s1_valid_d = accept && (px >= X_MIN) && (py >= Y_MIN);
        s1_eof_d   = accept && last_px;
        s1_x_d     = px - X_HALF;
        s1_y_d     = py - Y_HALF;
        bright_d   = '0;
        dark_d     = '0;
        bdiff_d    = '0;
        ddiff_d    = '0;
        for (int k = 0; k < CIRCLE_N; k++) begin
            r          = 3'(3 - circle_dy(4'(k)));
            col        = 3'(3 - circle_dx(4'(k)));
            p          = win[r][col];
            bright_d[k] = {1'b0, p} > c_plus_t;
            dark_d[k]   = $signed({2'b00, p}) < c_minus_t;
            // Only read when the matching mask bit is set, so PD bits never wrap there.
            bdiff_d[k]  = p - c - thr_d;
            ddiff_d[k]  = c - thr_d - p;
        end
    end

    fast_arc_detect u_bright_arc (
        .mask    (bright_q),
        .arc_len (ARC),
        .hit     (bright_hit)
    );

    fast_arc_detect u_dark_arc (
        .mask    (dark_q),
        .arc_len (ARC),
        .hit     (dark_hit)
    );

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_eof_d   = s1_eof_q;
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;
        bhit_d     = bright_hit;
        dhit_d     = dark_hit;
        bsum_d     = '0;
        dsum_d     = '0;
        for (int k = 0; k < CIRCLE_N; k++) begin
            if (bright_q[k]) bsum_d = bsum_d + SW'(bdiff_q[k]);
            if (dark_q[k])   dsum_d = dsum_d + SW'(ddiff_q[k]);
        end
    end

    always_comb begin
        out_valid_d  = s2_valid_q;
        out_corner_d = out_corner_q;
        out_score_d  = out_score_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_eof_d    = out_eof_q;
        if (s2_valid_q) begin
            out_corner_d = bhit_q || dhit_q;
            out_score_d  = bhit_q ? bsum_q : (dhit_q ? dsum_q : '0);
            out_x_d      = s2_x_q;
            out_y_d      = s2_y_q;
            out_eof_d    = s2_eof_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            thr_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_eof_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            bright_q     <= '0;
            dark_q       <= '0;
            bdiff_q      <= '0;
            ddiff_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_eof_q     <= 1'b0;
            s2_x_q       <= '0;
            s2_y_q       <= '0;
            bhit_q       <= 1'b0;
            dhit_q       <= 1'b0;
            bsum_q       <= '0;
            dsum_q       <= '0;
            out_valid_q  <= 1'b0;
            out_corner_q <= 1'b0;
            out_score_q  <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_eof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            thr_q        <= thr_d;
            s1_valid_q   <= s1_valid_d;
            s1_eof_q     <= s1_eof_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            bright_q     <= bright_d;
            dark_q       <= dark_d;
            bdiff_q      <= bdiff_d;
            ddiff_q      <= ddiff_d;
            s2_valid_q   <= s2_valid_d;
            s2_eof_q     <= s2_eof_d;
            s2_x_q       <= s2_x_d;
            s2_y_q       <= s2_y_d;
            bhit_q       <= bhit_d;
            dhit_q       <= dhit_d;
            bsum_q       <= bsum_d;
            dsum_q       <= dsum_d;
            out_valid_q  <= out_valid_d;
            out_corner_q <= out_corner_d;
            out_score_q  <= out_score_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_corner = out_corner_q;
    assign out_score  = out_score_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_eof    = out_eof_q;

endmodule

// File: tb/tb_fast_corner_detect.sv
// tb/tb_fast_corner_detect.sv - scoreboard bench for fast_corner_detect on a small 16x12 image
module tb_fast_corner_detect;

    localparam int W   = 16;
    localparam int H   = 12;
    localparam int ARC = 9;

    typedef logic [6:0][6:0][7:0] win_t;
    typedef struct {
        int due;
        int corner;
        int score;
        int x;
        int y;
        int eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    win_t        win;
    logic [7:0]  threshold;
    logic        out_valid;
    logic        out_corner;
    logic [11:0] out_score;
    logic [3:0]  out_x;
    logic [3:0]  out_y;
    logic        out_eof;

    fast_corner_detect #(
        .PIXEL_DEPTH (8),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .ARC_LEN     (ARC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .win        (win),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_corner (out_corner),
        .out_score  (out_score),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];
    exp_t last_exp;
    int   m_active = 0;
    int   m_idx    = 0;
    int   m_t      = 0;
    int   cdx[16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int   cdy[16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d", name, got, exp);
    endtask

    function automatic logic [21:0] hold_pack(input logic c, input logic [11:0] s,
                                              input logic [3:0] x, input logic [3:0] y,
                                              input logic e);
        return {c, s, x, y, e};
    endfunction

    function automatic int has_arc(input logic [15:0] m);
        for (int s = 0; s < 16; s++) begin
            int run;
            run = 0;
            while (run < 16 && m[(s + run) % 16]) run++;
            if (run >= ARC) return 1;
        end
        return 0;
    endfunction

    // Reference: classify each circle pixel with plain integer arithmetic and sum the margins.
    function automatic exp_t expect_of(input win_t w, input int t, input int x, input int y);
        exp_t        e;
        logic [15:0] br, dk;
        int          c, p, bs, ds, bh, dh;
        c = w[3][3];
        bs = 0; ds = 0; br = '0; dk = '0;
        for (int k = 0; k < 16; k++) begin
            p = w[3 - cdy[k]][3 - cdx[k]];
            if (p > c + t) begin br[k] = 1'b1; bs += p - c - t; end
            if (p < c - t) begin dk[k] = 1'b1; ds += c - t - p; end
        end
        bh = has_arc(br);
        dh = has_arc(dk);
        e.due    = cyc + 3;
        e.corner = (bh != 0 || dh != 0) ? 1 : 0;
        e.score  = (bh != 0) ? bs : ((dh != 0) ? ds : 0);
        e.x      = x - 3;
        e.y      = y - 3;
        e.eof    = (x == W - 1 && y == H - 1) ? 1 : 0;
        return e;
    endfunction

    task automatic model_step(input logic s, input win_t w, input logic [7:0] th);
        int x, y;
        if (s) begin
            m_active = 1;
            m_idx    = 0;
            m_t      = th;
        end
        if (m_active == 0) return;
        x = m_idx % W;
        y = m_idx / W;
        if (x >= 6 && y >= 6) exp_q.push_back(expect_of(w, m_t, x, y));
        m_idx++;
        if (m_idx == W * H) m_active = 0;
    endtask

    function automatic win_t gen(input int kind, input int t);
        win_t w;
        int   c, s, len, lo, hi, p, in_arc;
        for (int r = 0; r < 7; r++)
            for (int q = 0; q < 7; q++)
                w[r][q] = (kind == 0) ? 8'd100 : 8'($urandom_range(0, 255));
        case (kind)
            2:       c = $urandom_range(0, 254 - t);
            3:       c = $urandom_range(t + 1, 255);
            4:       c = $urandom_range(t, 255 - t);
            5, 6, 7: c = 100;
            8, 9:    c = 200;
            default: c = w[3][3];
        endcase
        s   = $urandom_range(0, 15);
        len = $urandom_range(7, 16);
        lo  = (c - t < 0) ? 0 : c - t;
        hi  = (c + t > 255) ? 255 : c + t;
        for (int k = 0; k < 16; k++) begin
            in_arc = (((k - s + 16) % 16) < len) ? 1 : 0;
            case (kind)
                2:       p = (in_arc != 0) ? $urandom_range(c + t + 1, 255) : $urandom_range(lo, hi);
                3:       p = (in_arc != 0) ? $urandom_range(0, c - t - 1) : $urandom_range(lo, hi);
                4:       p = ($urandom_range(0, 1) != 0) ? c + t : c - t;
                5:       p = (k <= 8) ? 150 : 100;
                6:       p = (k <= 7) ? 150 : 100;
                7:       p = (k >= 12 || k <= 4) ? 150 : 100;
                8:       p = 0;
                9:       p = 190;
                default: p = w[3 - cdy[k]][3 - cdx[k]];
            endcase
            w[3 - cdy[k]][3 - cdx[k]] = 8'(p);
        end
        w[3][3] = 8'(c);
        return w;
    endfunction

    task automatic drive(input logic v, input logic s, input win_t w, input logic [7:0] th);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_sof    = s;
        win       = w;
        threshold = th;
        if (v) model_step(s, w, th);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        exp_q.delete();
        m_active = 0;
        last_exp.due = 0; last_exp.corner = 0; last_exp.score = 0;
        last_exp.x = 0; last_exp.y = 0; last_exp.eof = 0;
        repeat (n) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_corner", out_corner, 0);
        chk("rst_score", out_score, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_eof", out_eof, 0);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // mode 0 flat, 1 random mix, 2 bright directed (t=20), 3 dark directed (t=10)
    task automatic run_frame(input int n_pix, input int mode, input int t0);
        for (int i = 0; i < n_pix; i++) begin
            int         kind;
            logic [7:0] th;
            if ($urandom_range(0, 4) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), gen(1, 0), 8'($urandom_range(0, 255)));
            case (mode)
                0:       kind = 0;
                1:       kind = $urandom_range(1, 4);
                2:       kind = 5 + i % 3;
                default: kind = 8 + i % 2;
            endcase
            th = (i == 0) ? 8'(t0) : 8'($urandom_range(0, 255));
            drive(1'b1, i == 0, gen(kind, t0), th);
        end
    endtask

    task automatic strays(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, gen(1, 0), 8'($urandom_range(0, 255)));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_valid got x=%0d y=%0d exp no result", out_x, out_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("x", out_x, e.x);
                    chk("y", out_y, e.y);
                    chk("corner", out_corner, e.corner);
                    chk("score", out_score, e.score);
                    chk("eof", out_eof, e.eof);
                    last_exp = e;
                end
            end else begin
                chk("hold", hold_pack(out_corner, out_score, out_x, out_y, out_eof),
                    hold_pack(1'(last_exp.corner), 12'(last_exp.score), 4'(last_exp.x),
                              4'(last_exp.y), 1'(last_exp.eof)));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        win       = '0;
        threshold = '0;
        do_reset(3);

        run_frame(W * H, 0, 20);
        strays(5);
        run_frame(W * H, 1, $urandom_range(0, 60));
        run_frame(W * H, 1, $urandom_range(0, 60));

        run_frame(100, 1, $urandom_range(0, 60));
        run_frame(W * H, 1, $urandom_range(0, 60));

        run_frame(120, 1, $urandom_range(0, 60));
        do_reset(1);
        strays(20);
        run_frame(W * H, 1, $urandom_range(0, 60));

        run_frame(W * H, 2, 20);
        run_frame(W * H, 3, 10);

        drive(1'b0, 1'b0, '0, 8'd0);
        repeat (6) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
